// File: rtl/pipelined_csel_adder_if.sv
// rtl/pipelined_csel_adder_if.sv - operand/result handshake bundle for pipelined_csel_adder (zero flag under ADDER_ZERO_FLAG_EN)
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef ADDER_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
`ifdef ADDER_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
`ifdef ADDER_ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - pipelined carry-select add/sub, one segment per stage; ADDER_ZERO_FLAG_EN adds a registered zero flag
module pipelined_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_csel_adder_if.slave adder_if
);
  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] en;
  logic [WIDTH-1:0]  b_eff;
  logic              c_in_eff;

  assign b_eff    = adder_if.sub ? ~adder_if.b : adder_if.b;
  assign c_in_eff = adder_if.sub | adder_if.cin;

  // Stage enables: a stage may load when empty or when the stage after it moves
  always_comb begin
    en = '0;
    en[STAGES-1] = ~v_q[STAGES-1] | adder_if.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = ~v_q[k] | en[k+1];
    end
  end

  assign v_d = (en & v_in) | (~en & v_q);

  // Valid bits; reset drops every in-flight operation at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RES = SEG * (k + 1);

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_sel;
    logic [SEG:0]   s0;
    logic [SEG:0]   s1;
    logic [SEG:0]   sel;
    logic [RES-1:0] sum_d;
    logic [RES-1:0] sum_q;
    logic           c_d;
    logic           c_q;
    logic           load;

    if (k == 0) begin : g_src
      assign a_seg   = adder_if.a[SEG-1:0];
      assign b_seg   = b_eff[SEG-1:0];
      assign c_sel   = c_in_eff;
      assign v_in[k] = adder_if.in_valid;
      assign sum_d   = sel[SEG-1:0];
    end else begin : g_src
      assign a_seg   = g_stage[k-1].g_rem.a_rem_q[SEG-1:0];
      assign b_seg   = g_stage[k-1].g_rem.b_rem_q[SEG-1:0];
      assign c_sel   = g_stage[k-1].c_q;
      assign v_in[k] = v_q[k-1];
      assign sum_d   = {sel[SEG-1:0], g_stage[k-1].sum_q};
    end

    // Both speculative sums are formed up front; the incoming carry only picks one
    assign s0   = {1'b0, a_seg} + {1'b0, b_seg};
    assign s1   = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, 1'b1};
    assign sel  = c_sel ? s1 : s0;
    assign c_d  = sel[SEG];
    assign load = en[k] & v_in[k];

    // Resolved sum bits and segment carry; bubbles leave the data untouched
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (load) begin
        sum_q <= sum_d;
        c_q   <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int REM = WIDTH - RES;
      logic [REM-1:0] a_rem_d;
      logic [REM-1:0] b_rem_d;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_q;

      if (k == 0) begin : g_src
        assign a_rem_d = adder_if.a[WIDTH-1:SEG];
        assign b_rem_d = b_eff[WIDTH-1:SEG];
      end else begin : g_src
        assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[REM+SEG-1:SEG];
        assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[REM+SEG-1:SEG];
      end

      // Unresolved operand bits ride along right-aligned for the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (load) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_cin_d;
      logic msb_cin_q;

      // Carry into the MSB is recovered from the MSB's own sum bit
      assign msb_cin_d = a_seg[SEG-1] ^ b_seg[SEG-1] ^ sel[SEG-1];

      // MSB carry-in kept beside the final carry so ovf is a pure register XOR
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    msb_cin_q <= 1'b0;
        else if (load) msb_cin_q <= msb_cin_d;
      end
    end

`ifdef ADDER_ZERO_FLAG_EN
    logic z_d;
    logic z_q;

    if (k == 0) begin : g_zsrc
      assign z_d = (sel[SEG-1:0] == '0);
    end else begin : g_zsrc
      assign z_d = g_stage[k-1].z_q & (sel[SEG-1:0] == '0);
    end

    // Zero flag accumulated one segment at a time alongside the sum
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    z_q <= 1'b0;
      else if (load) z_q <= z_d;
    end
`endif
  end

  assign adder_if.in_ready  = en[0];
  assign adder_if.out_valid = v_q[STAGES-1];
  assign adder_if.sum       = g_stage[STAGES-1].sum_q;
  assign adder_if.cout      = g_stage[STAGES-1].c_q;
  assign adder_if.ovf       = g_stage[STAGES-1].g_last.msb_cin_q ^ g_stage[STAGES-1].c_q;
`ifdef ADDER_ZERO_FLAG_EN
  assign adder_if.zero      = g_stage[STAGES-1].z_q;
`endif
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb/tb_pipelined_csel_adder.sv - directed checks for pipelined_csel_adder at 32/2 and 64/4
module tb_pipelined_csel_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_csel_adder_if #(.WIDTH(32)) if32 ();
  pipelined_csel_adder_if #(.WIDTH(64)) if64 ();

  pipelined_csel_adder #(.WIDTH(32), .STAGES(2)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .adder_if (if32)
  );

  pipelined_csel_adder #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .adder_if (if64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single operation on the 32/2 instance; entered and left at posedge+1
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub,
                      input logic [31:0] es, input logic ec, input logic eo);
    if32.a        = a;
    if32.b        = b;
    if32.cin      = cin;
    if32.sub      = sub;
    if32.in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, if32.in_ready, 1);
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    check({tag, "_lat1_valid"}, if32.out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, if32.out_valid, 1);
    check({tag, "_sum"}, if32.sum, es);
    check({tag, "_cout"}, if32.cout, ec);
    check({tag, "_ovf"}, if32.ovf, eo);
`ifdef ADDER_ZERO_FLAG_EN
    check({tag, "_zero"}, if32.zero, (es == 32'h0));
`endif
    @(posedge clk); #1;
  endtask

  int          st_or   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  int          exp_ir  [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  int          exp_ov  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int          exp_sum [9] = '{0, 0, 1, 1, 1, 2, 3, 4, 0};

  logic [63:0] va [8];
  logic [63:0] vb [8];
  logic        vsub [8];
  logic        vcin [8];
  logic [63:0] es64 [8];
  logic        ec64 [8];
  logic        eo64 [8];

  initial begin
    int          idx;
    logic [63:0] beff;
    logic [64:0] t;

    rst_n          = 1'b0;
    if32.in_valid  = 1'b0;
    if32.a         = '0;
    if32.b         = '0;
    if32.cin       = 1'b0;
    if32.sub       = 1'b0;
    if32.out_ready = 1'b1;
    if64.in_valid  = 1'b0;
    if64.a         = '0;
    if64.b         = '0;
    if64.cin       = 1'b0;
    if64.sub       = 1'b0;
    if64.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", if32.out_valid, 0);
    check("rst_sum", if32.sum, 0);
    check("rst_cout", if32.cout, 0);
    check("rst_ovf", if32.ovf, 0);
    check("rst_in_ready", if32.in_ready, 1);
    check("rst64_out_valid", if64.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run1("seg_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    run1("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run1("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run1("sub_borrow",32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run1("sub_ok",    32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run1("add_cin",   32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
    run1("sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    idx = 0;
    for (int c = 0; c < 9; c++) begin
      if32.out_ready = (st_or[c] != 0);
      if32.in_valid  = (idx < 4);
      if32.a         = 32'(idx);
      if32.b         = 32'h1;
      if32.cin       = 1'b0;
      if32.sub       = 1'b0;
      #1;
      check($sformatf("stall_in_ready_c%0d", c), if32.in_ready, exp_ir[c] != 0);
      check($sformatf("stall_out_valid_c%0d", c), if32.out_valid, exp_ov[c] != 0);
      if (exp_ov[c] != 0) check($sformatf("stall_sum_c%0d", c), if32.sum, 64'(exp_sum[c]));
      if (if32.in_valid && if32.in_ready) idx++;
      @(posedge clk); #1;
    end
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    check("stall_accepted", 64'(idx), 4);

    if32.a        = 32'd10;
    if32.b        = 32'd20;
    if32.in_valid = 1'b1;
    @(posedge clk); #1;
    if32.a        = 32'd100;
    if32.b        = 32'd200;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    check("midrst_pre_valid", if32.out_valid, 1);
    check("midrst_pre_sum", if32.sum, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", if32.out_valid, 0);
    check("midrst_sum", if32.sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_no_stale", if32.out_valid, 0);
    end

    va[0] = 64'hFFFFFFFFFFFFFFFF; vb[0] = 64'h1;                vsub[0] = 1'b0; vcin[0] = 1'b0;
    es64[0] = 64'h0;               ec64[0] = 1'b1;              eo64[0] = 1'b0;
    va[1] = 64'h0123456789ABCDEF; vb[1] = 64'h0123456789ABCDEF; vsub[1] = 1'b1; vcin[1] = 1'b0;
    es64[1] = 64'h0;               ec64[1] = 1'b1;              eo64[1] = 1'b0;
    va[2] = 64'h0000FFFFFFFFFFFF; vb[2] = 64'h1;                vsub[2] = 1'b0; vcin[2] = 1'b0;
    es64[2] = 64'h0001000000000000; ec64[2] = 1'b0;             eo64[2] = 1'b0;
    va[3] = 64'h8000000000000000; vb[3] = 64'h1;                vsub[3] = 1'b1; vcin[3] = 1'b1;
    es64[3] = 64'h7FFFFFFFFFFFFFFF; ec64[3] = 1'b1;             eo64[3] = 1'b1;
    for (int i = 4; i < 8; i++) begin
      va[i]   = {$urandom, $urandom};
      vb[i]   = {$urandom, $urandom};
      vsub[i] = 1'($urandom_range(0, 1));
      vcin[i] = 1'($urandom_range(0, 1));
      beff    = vsub[i] ? ~vb[i] : vb[i];
      t       = {1'b0, va[i]} + {1'b0, beff} + 65'(vsub[i] | vcin[i]);
      es64[i] = t[63:0];
      ec64[i] = t[64];
      eo64[i] = (va[i][63] == beff[63]) && (t[63] != va[i][63]);
    end

    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        if64.in_valid = 1'b1;
        if64.a        = va[c];
        if64.b        = vb[c];
        if64.sub      = vsub[c];
        if64.cin      = vcin[c];
      end else begin
        if64.in_valid = 1'b0;
      end
      #1;
      if (c < 8) check($sformatf("w64_in_ready_c%0d", c), if64.in_ready, 1);
      check($sformatf("w64_out_valid_c%0d", c), if64.out_valid, (c >= 4 && c < 12));
      if (c >= 4 && c < 12) begin
        check($sformatf("w64_sum_op%0d", c - 4), if64.sum, es64[c-4]);
        check($sformatf("w64_cout_op%0d", c - 4), if64.cout, ec64[c-4]);
        check($sformatf("w64_ovf_op%0d", c - 4), if64.ovf, eo64[c-4]);
`ifdef ADDER_ZERO_FLAG_EN
        check($sformatf("w64_zero_op%0d", c - 4), if64.zero, (es64[c-4] == 64'h0));
`endif
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
